// File: rtl/vdp_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vdp_port_ctrl
// Description : CPU-side front end of the VDP. Decodes the two-port protocol
//               (control port: address/code latch and register writes; data
//               port: VRAM/CRAM data) and keeps the VRAM read-ahead buffer
//               returned on data-port reads.
// Ports       : clk, reset_n        - clock, synchronous active-low reset
//               io_*                - CPU bus (port select, strobes, data)
//               status_in/status_rd - status byte and its clear-on-read pulse
//               reg_*               - VDP register write (registered)
//               cram_*              - palette RAM write (registered)
//               vram_*              - VRAM read/write (registered), read data
//                                     valid the cycle after vram_rden
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_port_ctrl #(
    parameter int VADDR_W = 14,
    parameter int PAL_AW  = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               io_portsel,
    input  logic [7:0]         io_wrdata,
    input  logic               io_wren,
    input  logic               io_rden,
    output logic [7:0]         io_rddata,
    input  logic [7:0]         status_in,
    output logic               status_rd,
    output logic [3:0]         reg_addr,
    output logic [7:0]         reg_data,
    output logic               reg_wren,
    output logic [PAL_AW-1:0]  cram_addr,
    output logic [7:0]         cram_wrdata,
    output logic               cram_wren,
    output logic [VADDR_W-1:0] vram_addr,
    output logic [7:0]         vram_wrdata,
    output logic               vram_wren,
    output logic               vram_rden,
    input  logic [7:0]         vram_rddata
);

    localparam logic [VADDR_W-1:0] C_ADDR_ONE = VADDR_W'(1);
    localparam logic [1:0]         C_CODE_RD  = 2'd0;
    localparam logic [1:0]         C_CODE_REG = 2'd2;
    localparam logic [1:0]         C_CODE_PAL = 2'd3;

    // Protocol state
    logic [VADDR_W-1:0] addr_q, addr_d;
    logic [1:0]         code_q, code_d;
    logic               flag_q, flag_d;
    logic [7:0]         buf_q, buf_d;
    // High during the cycle the fetched VRAM byte is on vram_rddata
    logic               fetch_pending_q, fetch_pending_d;

    // Registered outputs
    logic [3:0]         reg_addr_q, reg_addr_d;
    logic [7:0]         reg_data_q, reg_data_d;
    logic               reg_wren_q, reg_wren_d;
    logic [PAL_AW-1:0]  cram_addr_q, cram_addr_d;
    logic [7:0]         cram_wrdata_q, cram_wrdata_d;
    logic               cram_wren_q, cram_wren_d;
    logic [VADDR_W-1:0] vram_addr_q, vram_addr_d;
    logic [7:0]         vram_wrdata_q, vram_wrdata_d;
    logic               vram_wren_q, vram_wren_d;
    logic               vram_rden_q, vram_rden_d;

    logic [VADDR_W-1:0] w_addr_new;
    logic [VADDR_W-1:0] w_fetch_addr;
    logic               w_fetch;

    // Address after the second control byte: new high bits, old low byte
    assign w_addr_new = {io_wrdata[VADDR_W-9:0], addr_q[7:0]};

    always_comb begin
        addr_d          = addr_q;
        code_d          = code_q;
        flag_d          = flag_q;
        buf_d           = buf_q;
        fetch_pending_d = vram_rden_q;
        reg_addr_d      = reg_addr_q;
        reg_data_d      = reg_data_q;
        reg_wren_d      = 1'b0;
        cram_addr_d     = cram_addr_q;
        cram_wrdata_d   = cram_wrdata_q;
        cram_wren_d     = 1'b0;
        vram_addr_d     = vram_addr_q;
        vram_wrdata_d   = vram_wrdata_q;
        vram_wren_d     = 1'b0;
        vram_rden_d     = 1'b0;
        w_fetch         = 1'b0;
        w_fetch_addr    = addr_q;

        // Capture first so that a data write in the same cycle overrides it
        if (fetch_pending_q) begin
            buf_d = vram_rddata;
        end

        if (io_wren) begin
            if (io_portsel) begin
                if (!flag_q) begin
                    addr_d[7:0] = io_wrdata;
                    flag_d      = 1'b1;
                end else begin
                    addr_d = w_addr_new;
                    code_d = io_wrdata[7:6];
                    flag_d = 1'b0;
                    if (io_wrdata[7:6] == C_CODE_RD) begin
                        w_fetch      = 1'b1;
                        w_fetch_addr = w_addr_new;
                    end else if (io_wrdata[7:6] == C_CODE_REG) begin
                        reg_wren_d = 1'b1;
                        reg_addr_d = io_wrdata[3:0];
                        reg_data_d = addr_q[7:0];
                    end
                end
            end else begin
                flag_d = 1'b0;
                buf_d  = io_wrdata;
                if (code_q == C_CODE_PAL) begin
                    cram_wren_d   = 1'b1;
                    cram_addr_d   = addr_q[PAL_AW-1:0];
                    cram_wrdata_d = io_wrdata;
                end else begin
                    vram_wren_d   = 1'b1;
                    vram_addr_d   = addr_q;
                    vram_wrdata_d = io_wrdata;
                end
                addr_d = addr_q + C_ADDR_ONE;
            end
        end else if (io_rden) begin
            // A read that coincides with a write is ignored (branch above)
            flag_d = 1'b0;
            if (!io_portsel) begin
                w_fetch = 1'b1;
            end
        end

        // Read-ahead: issue the VRAM read and post-increment the address
        if (w_fetch) begin
            vram_rden_d = 1'b1;
            vram_addr_d = w_fetch_addr;
            addr_d      = w_fetch_addr + C_ADDR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q          <= '0;
            code_q          <= '0;
            flag_q          <= 1'b0;
            buf_q           <= '0;
            fetch_pending_q <= 1'b0;
            reg_addr_q      <= '0;
            reg_data_q      <= '0;
            reg_wren_q      <= 1'b0;
            cram_addr_q     <= '0;
            cram_wrdata_q   <= '0;
            cram_wren_q     <= 1'b0;
            vram_addr_q     <= '0;
            vram_wrdata_q   <= '0;
            vram_wren_q     <= 1'b0;
            vram_rden_q     <= 1'b0;
        end else begin
            addr_q          <= addr_d;
            code_q          <= code_d;
            flag_q          <= flag_d;
            buf_q           <= buf_d;
            fetch_pending_q <= fetch_pending_d;
            reg_addr_q      <= reg_addr_d;
            reg_data_q      <= reg_data_d;
            reg_wren_q      <= reg_wren_d;
            cram_addr_q     <= cram_addr_d;
            cram_wrdata_q   <= cram_wrdata_d;
            cram_wren_q     <= cram_wren_d;
            vram_addr_q     <= vram_addr_d;
            vram_wrdata_q   <= vram_wrdata_d;
            vram_wren_q     <= vram_wren_d;
            vram_rden_q     <= vram_rden_d;
        end
    end

    // CPU read data and status clear pulse are combinational
    assign io_rddata   = io_portsel ? status_in : buf_q;
    assign status_rd   = reset_n & io_rden & ~io_wren & io_portsel;

    assign reg_addr    = reg_addr_q;
    assign reg_data    = reg_data_q;
    assign reg_wren    = reg_wren_q;
    assign cram_addr   = cram_addr_q;
    assign cram_wrdata = cram_wrdata_q;
    assign cram_wren   = cram_wren_q;
    assign vram_addr   = vram_addr_q;
    assign vram_wrdata = vram_wrdata_q;
    assign vram_wren   = vram_wren_q;
    assign vram_rden   = vram_rden_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vdp_port_ctrl
// Description : Self-checking bench for vdp_port_ctrl with a VRAM model and a
//               behavioural protocol reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_port_ctrl;

    localparam int MEMSZ = 16384;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_portsel = 1'b0;
    logic [7:0]  io_wrdata = 8'h00;
    logic        io_wren = 1'b0;
    logic        io_rden = 1'b0;
    logic [7:0]  io_rddata;
    logic [7:0]  status_in = 8'h00;
    logic        status_rd;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        reg_wren;
    logic [4:0]  cram_addr;
    logic [7:0]  cram_wrdata;
    logic        cram_wren;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wrdata;
    logic        vram_wren;
    logic        vram_rden;
    logic [7:0]  vram_rddata = 8'h00;

    // VRAM model, written only by this process
    logic [7:0]  tb_mem [0:MEMSZ-1];
    logic        pl_en = 1'b0;
    logic [13:0] pl_addr = 14'h0;
    logic [7:0]  pl_data = 8'h00;

    // Reference model state
    logic [7:0]  ref_mem [0:MEMSZ-1];
    int          m_addr;
    int          m_code;
    bit          m_flag;
    logic [7:0]  m_buf;

    int checks = 0;
    int errors = 0;

    vdp_port_ctrl #(.VADDR_W(14), .PAL_AW(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .io_portsel(io_portsel), .io_wrdata(io_wrdata), .io_wren(io_wren),
        .io_rden(io_rden), .io_rddata(io_rddata),
        .status_in(status_in), .status_rd(status_rd),
        .reg_addr(reg_addr), .reg_data(reg_data), .reg_wren(reg_wren),
        .cram_addr(cram_addr), .cram_wrdata(cram_wrdata), .cram_wren(cram_wren),
        .vram_addr(vram_addr), .vram_wrdata(vram_wrdata), .vram_wren(vram_wren),
        .vram_rden(vram_rden), .vram_rddata(vram_rddata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en)     tb_mem[pl_addr] <= pl_data;
        if (vram_wren) tb_mem[vram_addr] <= vram_wrdata;
        if (vram_rden) vram_rddata <= tb_mem[vram_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_code = 0;
        m_flag = 1'b0;
        m_buf  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check("idle_strobes", 16'({reg_wren, cram_wren, vram_wren, vram_rden}), 16'h0);
        end
    endtask

    // One CPU access in a single cycle, checked against the model; gap idle
    // cycles follow so the read-ahead has completed before the next access.
    task automatic op(input logic ps, input logic wr, input logic rd,
                      input logic [7:0] d, input int gap);
        logic e_reg, e_cram, e_vwr, e_vrd, do_fetch;
        int   e_ra, e_rd, e_ca, e_cd, e_va, e_vd, e_fa;
        e_reg = 0; e_cram = 0; e_vwr = 0; e_vrd = 0; do_fetch = 0;
        e_ra = 0; e_rd = 0; e_ca = 0; e_cd = 0; e_va = 0; e_vd = 0; e_fa = 0;
        @(posedge clk); #1;
        io_portsel = ps; io_wren = wr; io_rden = rd; io_wrdata = d;
        #1;
        if (rd && !wr)
            check("io_rddata", 16'(io_rddata), ps ? 16'(status_in) : 16'(m_buf));
        check("status_rd", 16'(status_rd), 16'(rd && !wr && ps));

        if (wr) begin
            if (ps) begin
                if (!m_flag) begin
                    m_addr = (m_addr / 256) * 256 + int'(d);
                    m_flag = 1'b1;
                end else begin
                    e_rd   = m_addr % 256;
                    m_addr = (int'(d) % 64) * 256 + (m_addr % 256);
                    m_code = int'(d) / 64;
                    m_flag = 1'b0;
                    if (m_code == 0) do_fetch = 1;
                    if (m_code == 2) begin
                        e_reg = 1;
                        e_ra  = int'(d) % 16;
                    end
                end
            end else begin
                m_flag = 1'b0;
                m_buf  = d;
                if (m_code == 3) begin
                    e_cram = 1; e_ca = m_addr % 32; e_cd = int'(d);
                end else begin
                    e_vwr = 1; e_va = m_addr; e_vd = int'(d);
                    ref_mem[m_addr] = d;
                end
                m_addr = (m_addr + 1) % MEMSZ;
            end
        end else if (rd) begin
            m_flag = 1'b0;
            if (!ps) do_fetch = 1;
        end
        if (do_fetch) begin
            e_vrd  = 1;
            e_fa   = m_addr;
            m_buf  = ref_mem[m_addr];
            m_addr = (m_addr + 1) % MEMSZ;
        end

        @(posedge clk); #1;
        io_wren = 1'b0; io_rden = 1'b0;
        check("reg_wren", 16'(reg_wren), 16'(e_reg));
        if (e_reg) begin
            check("reg_addr", 16'(reg_addr), 16'(e_ra));
            check("reg_data", 16'(reg_data), 16'(e_rd));
        end
        check("cram_wren", 16'(cram_wren), 16'(e_cram));
        if (e_cram) begin
            check("cram_addr", 16'(cram_addr), 16'(e_ca));
            check("cram_wrdata", 16'(cram_wrdata), 16'(e_cd));
        end
        check("vram_wren", 16'(vram_wren), 16'(e_vwr));
        if (e_vwr) begin
            check("vram_wr_addr", 16'(vram_addr), 16'(e_va));
            check("vram_wrdata", 16'(vram_wrdata), 16'(e_vd));
        end
        check("vram_rden", 16'(vram_rden), 16'(e_vrd));
        if (e_vrd)
            check("vram_rd_addr", 16'(vram_addr), 16'(e_fa));
        idle(gap);
    endtask

    task automatic ctrl_wr(input logic [7:0] d);
        op(1'b1, 1'b1, 1'b0, d, 2);
    endtask

    task automatic data_wr(input logic [7:0] d);
        op(1'b0, 1'b1, 1'b0, d, 2);
    endtask

    task automatic data_rd();
        op(1'b0, 1'b0, 1'b1, 8'h00, 2);
    endtask

    // Reset pulse of one clock edge; outputs must come back cleared
    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        check("rst_strobes", 16'({reg_wren, cram_wren, vram_wren, vram_rden}), 16'h0);
        check("rst_vram_addr", 16'(vram_addr), 16'h0);
        check("rst_vram_wrdata", 16'(vram_wrdata), 16'h0);
        check("rst_reg", 16'({reg_addr, reg_data}), 16'h0);
        check("rst_cram", 16'({cram_addr, cram_wrdata}), 16'h0);
    endtask

    initial begin
        model_reset();
        // Preload VRAM with a pattern while the DUT is held in reset
        for (int i = 0; i < MEMSZ; i++) begin
            @(posedge clk); #1;
            pl_en = 1'b1; pl_addr = 14'(i); pl_data = 8'((i * 37) + (i / 128));
            ref_mem[i] = 8'((i * 37) + (i / 128));
        end
        @(posedge clk); #1;
        pl_addr = 14'h1234; pl_data = 8'hAA; ref_mem[16'h1234] = 8'hAA;
        @(posedge clk); #1;
        pl_addr = 14'h1235; pl_data = 8'hBB; ref_mem[16'h1235] = 8'hBB;
        @(posedge clk); #1;
        pl_en = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Reset state
        check("reset_strobes", 16'({reg_wren, cram_wren, vram_wren, vram_rden}), 16'h0);
        check("reset_buf", 16'(io_rddata), 16'h0);

        // CRAM writes at 5 and 6
        ctrl_wr(8'h05); ctrl_wr(8'hC0);
        data_wr(8'h3F); data_wr(8'h15);

        // Register write: reg 1 <= 0x26
        ctrl_wr(8'h26); ctrl_wr(8'h81);

        // Read-ahead from 0x1234
        ctrl_wr(8'h34); ctrl_wr(8'h12);
        data_rd(); data_rd();

        // Control read clears the half-written address
        ctrl_wr(8'h10);
        status_in = 8'h80;
        op(1'b1, 1'b0, 1'b1, 8'h00, 2);
        ctrl_wr(8'h20); ctrl_wr(8'h40);
        data_wr(8'h77);

        // VRAM and CRAM address wrap
        ctrl_wr(8'hFF); ctrl_wr(8'h7F);
        data_wr(8'h11); data_wr(8'h22);
        ctrl_wr(8'h1F); ctrl_wr(8'hC0);
        data_wr(8'h33); data_wr(8'h44);

        // Reset with half-written address latch
        ctrl_wr(8'h55);
        do_reset();
        ctrl_wr(8'h00); ctrl_wr(8'h41);
        data_wr(8'h5A);

        // Reset in the middle of a read-ahead
        ctrl_wr(8'h40);
        op(1'b1, 1'b1, 1'b0, 8'h01, 0);
        do_reset();
        idle(2);
        data_rd();
        data_rd();

        // Data write lands in the capture cycle and wins
        ctrl_wr(8'h00);
        op(1'b1, 1'b1, 1'b0, 8'h02, 0);
        op(1'b0, 1'b1, 1'b0, 8'hC3, 2);
        data_rd();

        // Write and read together: the write is served
        ctrl_wr(8'h80); ctrl_wr(8'h43);
        op(1'b0, 1'b1, 1'b1, 8'h9E, 2);
        status_in = 8'h5C;
        op(1'b1, 1'b1, 1'b1, 8'h08, 2);
        ctrl_wr(8'h42);

        // Randomized accesses
        for (int k = 0; k < 120; k++) begin
            int kind;
            logic [7:0] d;
            kind = int'($urandom_range(0, 9));
            d = 8'($urandom);
            status_in = 8'($urandom);
            case (kind)
                0, 1, 2, 3: op(1'b1, 1'b1, 1'b0, d, 2);
                4, 5:       op(1'b0, 1'b1, 1'b0, d, 2);
                6, 7:       op(1'b0, 1'b0, 1'b1, d, 2);
                8:          op(1'b1, 1'b0, 1'b1, d, 2);
                default:    op(d[0], 1'b1, 1'b1, d, 2);
            endcase
        end
        data_rd();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vdp_port_ctrl.md
Name: vdp_port_ctrl

Overview:
CPU-side front end of the VDP. It decodes the two-port protocol: a control port for the address/code latch and register writes, and a data port for VRAM/CRAM data.
It produces the write strobes that fill the palette RAM (5-bit address, 8-bit data, 1-cycle strobe), the VRAM accesses, and the VDP register writes.
It also implements the VRAM read-ahead buffer returned on data-port reads.

Parameters:
VADDR_W, 14, VRAM address width; address counter wraps at 2^VADDR_W.
PAL_AW, 5, palette address width; CRAM address = low PAL_AW bits of the address counter.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
io_portsel  in  1  0 = data port, 1 = control port
io_wrdata  in  8  CPU write data
io_wren  in  1  1-cycle CPU write strobe
io_rden  in  1  1-cycle CPU read strobe
io_rddata  out  8  CPU read data, valid in the cycle io_rden is high (combinational mux)
status_in  in  8  VDP status byte, returned on control-port reads
status_rd  out  1  1-cycle pulse when the control port is read (status clear-on-read)
reg_addr  out  4  VDP register index
reg_data  out  8  VDP register value
reg_wren  out  1  1-cycle register write strobe
cram_addr  out  PAL_AW  palette write address
cram_wrdata  out  8  palette write data
cram_wren  out  1  1-cycle palette write strobe
vram_addr  out  VADDR_W  VRAM address
vram_wrdata  out  8  VRAM write data
vram_wren  out  1  1-cycle VRAM write strobe
vram_rden  out  1  1-cycle VRAM read strobe
vram_rddata  in  8  VRAM read data, valid the cycle after vram_rden

Behaviour:
- Reset (reset_n low at a clk edge), for any operation in flight:
  - addr = 0, code = 0, second_byte flag = 0, read buffer = 0, fetch_pending = 0.
  - All strobes are 0. reg_addr, reg_data, cram_*, vram_addr and vram_wrdata are 0.
  - A pending fetch is abandoned and the buffer stays 0.
- Registered outputs: every strobe and its address/data are registered, and assert in the cycle after the triggering io_* strobe.
- Control write, flag = 0:
  - addr[7:0] = io_wrdata; flag = 1. No other effect.
- Control write, flag = 1:
  - addr[13:8] = io_wrdata[5:0]; code = io_wrdata[7:6]; flag = 0.
  - Code 0: start a read-ahead at the new addr.
  - Code 2: reg_wren pulse with reg_addr = io_wrdata[3:0] and reg_data = addr[7:0]. addr[13:8] and code are still updated.
  - Codes 1 and 3: latch only.
- Control read:
  - io_rddata = status_in; status_rd pulses in the same cycle (combinational); flag = 0.
- Data write:
  - flag = 0; buffer = io_wrdata.
  - code == 3: cram_wren with cram_addr = addr[PAL_AW-1:0] and cram_wrdata = io_wrdata.
  - Otherwise: vram_wren with vram_addr = addr and vram_wrdata = io_wrdata.
  - Then addr = addr + 1, modulo 2^VADDR_W.
- Data read:
  - io_rddata = current buffer; flag = 0; start a read-ahead.
- Read-ahead:
  - Cycle T+1: vram_rden = 1 and vram_addr = addr (pre-increment); addr increments in the same cycle.
  - Cycle T+2: buffer = vram_rddata; fetch_pending clears.
- Address wrap: 0x3FFF + 1 = 0x0000, for both the data path and the read-ahead. CRAM wraps at 32 through bit truncation.
- Simultaneous events:
  - io_wren and io_rden both high in one cycle: the write is served and the read is ignored.
  - A data write that lands in the buffer-capture cycle overrides the fetched data (the write wins).
  - A new access while fetch_pending is set: the access is served normally and the pending capture still completes.
- At most one of reg_wren / cram_wren / vram_wren / vram_rden is high in any cycle.

Test Plan:
- Reset: hold reset_n = 0 mid-fetch for 1 cycle -> all strobes 0, buffer 0, flag 0; the next data read returns 0x00.
- CRAM write: ctrl 0x05, ctrl 0xC0, then data 0x3F, 0x15 -> cram_wren pulses at addr 5 (0x3F) and addr 6 (0x15); no vram_wren.
- Register write: ctrl 0x26, ctrl 0x81 -> single reg_wren with reg_addr = 1 and reg_data = 0x26.
- VRAM read-ahead: preload VRAM[0x1234] = 0xAA and [0x1235] = 0xBB; ctrl 0x34, ctrl 0x12 -> vram_rden at 0x1234. First data read returns 0xAA (vram_rden at 0x1235); second returns 0xBB.
- Flag clear: ctrl 0x10, control read (status_in = 0x80 returned, status_rd pulse), ctrl 0x20, ctrl 0x40 -> addr = 0x0020, code 1; data write 0x77 -> vram_wren at 0x0020.
- Wrap: set addr 0x3FFF code 1, two data writes -> vram_wren at 0x3FFF, then 0x0000. Set CRAM addr 31 -> writes at 31, then 0.
